// File: rtl/i2s_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2s_seq_pkg
// Shared definitions for the I2S -> PCM1702 frame sequencer:
//   - seq_state_t : sequencer states (search / acquire / locked)
//   - SLOT_24, SLOT_32 : supported LRCK half-frame lengths in BCK cycles
//   - RST_DELAY_R/L    : tap lengths matching the 32-bit slot default
//   - slot_len_valid() : true only for a supported slot length
// ---------------------------------------------------------------------------
package i2s_seq_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } seq_state_t;

  localparam int SLOT_24     = 24;
  localparam int SLOT_32     = 32;
  localparam int RST_DELAY_R = 11;
  localparam int RST_DELAY_L = 43;

  // 16-bit slots cannot carry a 20-bit word plus the latch slot, so only
  // 24 and 32 are accepted.
  function automatic logic slot_len_valid(input int len);
    return (len == SLOT_24) || (len == SLOT_32);
  endfunction

endpackage

// File: rtl/i2s_slot_meter.sv
// ---------------------------------------------------------------------------
// i2s_slot_meter
// Measures LRCK half-frame length in BCK cycles.
//   i_clk, i_rst   : BCK and asynchronous active-high reset
//   i_lrck         : I2S word clock
//   o_edge         : LRCK differs from its registered copy this cycle
//   o_fall         : o_edge with LRCK now low (left slot / frame start)
//   o_stall        : counter saturated with no edge (LRCK stopped)
//   o_len          : length of the slot ending at this edge (cnt+1, capped)
//   o_slot_len     : o_len captured at the last edge
// ---------------------------------------------------------------------------
module i2s_slot_meter #(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lrck,
  output logic             o_edge,
  output logic             o_fall,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_len,
  output logic [CNT_W-1:0] o_slot_len
);

  logic             r_lrck_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_slot_len;
  logic             w_sat;

  assign w_sat      = (r_cnt == {CNT_W{1'b1}});
  assign o_edge     = i_lrck ^ r_lrck_q;
  assign o_fall     = o_edge & ~i_lrck;
  assign o_stall    = w_sat & ~o_edge;
  // Capped so a stalled slot still reports the largest representable length.
  assign o_len      = w_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign o_slot_len = r_slot_len;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lrck_q   <= 1'b0;
      r_cnt      <= '0;
      r_slot_len <= '0;
    end else begin
      r_lrck_q <= i_lrck;
      if (o_edge) begin
        r_cnt      <= '0;
        r_slot_len <= o_len;
      end else if (!w_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_frame_sequencer
// Locks onto the I2S slot format, programs the delay-chain taps, generates the
// PCM1702 latch-enable pulse, gates the datapath and drives the status LED.
//   BCK, RST  : bit clock, asynchronous active-high reset
//   LRCK      : I2S word clock (low = left, high = right)
//   DELAY_R/L : right / left tap lengths (left = right + slot length)
//   LE        : latch enable, idle high; low for LE_WIDTH cycles starting one
//               cycle after a frame-start edge is seen while gated on
//   DGATE     : 1 passes data, 0 forces DATAOUTx low
//   LOCKED    : frame lock status
//   SLOT_LEN  : last measured slot length
//   FMT_ERR   : one-cycle pulse on an invalid or mismatched slot
//   LED1      : status LED, active low
// Optional build macro LED_ACQ_BLINK_EN: blink LED1 while acquiring instead
// of showing ~LOCKED.
// ---------------------------------------------------------------------------
module i2s_frame_sequencer
  import i2s_seq_pkg::*;
#(
  parameter int DATA_BITS   = 20,
  parameter int LOCK_HALVES = 4,
  parameter int LE_WIDTH    = 2,
  parameter int CNT_W       = 6
) (
  input  logic             BCK,
  input  logic             RST,
  input  logic             LRCK,
  output logic [CNT_W-1:0] DELAY_R,
  output logic [CNT_W:0]   DELAY_L,
  output logic             LE,
  output logic             DGATE,
  output logic             LOCKED,
  output logic [CNT_W-1:0] SLOT_LEN,
  output logic             FMT_ERR,
  output logic             LED1
);

  localparam int MW = $clog2(LOCK_HALVES + 1);
  localparam int LW = $clog2(LE_WIDTH + 1);

  logic             w_edge, w_fall, w_stall, w_valid;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_tap_r;
  logic [CNT_W:0]   w_tap_l;
  seq_state_t       w_state_nxt;
  logic [MW-1:0]    w_match_nxt;
  logic             w_fmt_nxt, w_tap_ld, w_dgate_nxt, w_le_trig;

  seq_state_t       r_state;
  logic [MW-1:0]    r_match;
  logic [CNT_W-1:0] r_prev_len, r_lock_len, r_delay_r;
  logic [CNT_W:0]   r_delay_l;
  logic             r_fmt_err, r_dgate, r_le, r_le_arm;
  logic [LW-1:0]    r_le_cnt;

  i2s_slot_meter #(.CNT_W(CNT_W)) u_meter (
    .i_clk      (BCK),
    .i_rst      (RST),
    .i_lrck     (LRCK),
    .o_edge     (w_edge),
    .o_fall     (w_fall),
    .o_stall    (w_stall),
    .o_len      (w_len),
    .o_slot_len (SLOT_LEN)
  );

  assign w_valid = slot_len_valid(int'(w_len));
  assign w_tap_r = w_len - CNT_W'(DATA_BITS + 1);
  assign w_tap_l = {1'b0, w_tap_r} + {1'b0, w_len};

  always_ff @(posedge BCK or posedge RST) begin
    if (RST) r_state <= ST_SEARCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_fmt_nxt   = 1'b0;
    w_tap_ld    = 1'b0;
    case (r_state)
      // First edge only marks a slot boundary; its length is partial.
      ST_SEARCH: begin
        if (w_edge) begin
          w_state_nxt = ST_ACQUIRE;
          w_match_nxt = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_stall) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_edge) begin
          if (w_valid && (r_match != '0) && (w_len == r_prev_len)) begin
            w_match_nxt = r_match + MW'(1);
          end else begin
            w_match_nxt = w_valid ? MW'(1) : '0;
            // The first valid slot after a restart is not a mismatch.
            w_fmt_nxt   = ~w_valid | (r_match != '0);
          end
          if (w_match_nxt == MW'(LOCK_HALVES)) begin
            w_state_nxt = ST_LOCKED;
            w_tap_ld    = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_stall) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_edge && (w_len != r_lock_len)) begin
          w_fmt_nxt   = 1'b1;
          w_state_nxt = ST_ACQUIRE;
          w_match_nxt = '0;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase

    // Gate opens only at a frame start seen while already locked.
    w_dgate_nxt = r_dgate;
    if (w_state_nxt != ST_LOCKED)             w_dgate_nxt = 1'b0;
    else if (r_state == ST_LOCKED && w_fall)  w_dgate_nxt = 1'b1;
  end

  always_ff @(posedge BCK or posedge RST) begin
    if (RST) begin
      r_match    <= '0;
      r_prev_len <= '0;
      r_lock_len <= '0;
      r_delay_r  <= CNT_W'(RST_DELAY_R);
      r_delay_l  <= (CNT_W+1)'(RST_DELAY_L);
      r_fmt_err  <= 1'b0;
      r_dgate    <= 1'b0;
    end else begin
      r_match   <= w_match_nxt;
      r_fmt_err <= w_fmt_nxt;
      r_dgate   <= w_dgate_nxt;
      if (w_edge) r_prev_len <= w_len;
      if (w_tap_ld) begin
        r_lock_len <= w_len;
        r_delay_r  <= w_tap_r;
        r_delay_l  <= w_tap_l;
      end
    end
  end

  // Latch pulse: arm on the trigger, go low the next cycle, count down.
  // Ignoring triggers while armed or low keeps every pulse full width.
  assign w_le_trig = w_fall & w_dgate_nxt & r_le & ~r_le_arm;

  always_ff @(posedge BCK or posedge RST) begin
    if (RST) begin
      r_le     <= 1'b1;
      r_le_arm <= 1'b0;
      r_le_cnt <= '0;
    end else begin
      r_le_arm <= w_le_trig;
      if (r_le_arm) begin
        r_le     <= 1'b0;
        r_le_cnt <= LW'(LE_WIDTH - 1);
      end else if (r_le_cnt != '0) begin
        r_le_cnt <= r_le_cnt - LW'(1);
      end else begin
        r_le <= 1'b1;
      end
    end
  end

  assign DELAY_R = r_delay_r;
  assign DELAY_L = r_delay_l;
  assign LE      = r_le;
  assign DGATE   = r_dgate;
  assign LOCKED  = (r_state == ST_LOCKED);
  assign FMT_ERR = r_fmt_err;

`ifdef LED_ACQ_BLINK_EN
  logic [CNT_W-1:0] r_frm;
  logic             r_blink;

  always_ff @(posedge BCK or posedge RST) begin
    if (RST) begin
      r_frm   <= '0;
      r_blink <= 1'b1;
    end else if (r_state != ST_ACQUIRE) begin
      r_frm   <= '0;
      r_blink <= 1'b1;
    end else if (w_fall) begin
      r_frm <= r_frm + CNT_W'(1);
      if (r_frm == {CNT_W{1'b1}}) r_blink <= ~r_blink;
    end
  end

  assign LED1 = (r_state == ST_LOCKED)  ? 1'b0 :
                (r_state == ST_ACQUIRE) ? r_blink : 1'b1;
`else
  assign LED1 = ~(r_state == ST_LOCKED);
`endif

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
module tb_i2s_frame_sequencer;

  localparam int DATA_BITS   = 20;
  localparam int LOCK_HALVES = 4;
  localparam int LE_WIDTH    = 2;
  localparam int CNT_W       = 6;

  logic       BCK = 1'b0;
  logic       RST = 1'b1;
  logic       LRCK = 1'b0;
  logic [5:0] DELAY_R, SLOT_LEN;
  logic [6:0] DELAY_L;
  logic       LE, DGATE, LOCKED, FMT_ERR, LED1;

  always #5 BCK = ~BCK;

  i2s_frame_sequencer #(
    .DATA_BITS(DATA_BITS), .LOCK_HALVES(LOCK_HALVES),
    .LE_WIDTH(LE_WIDTH), .CNT_W(CNT_W)
  ) dut (
    .BCK(BCK), .RST(RST), .LRCK(LRCK),
    .DELAY_R(DELAY_R), .DELAY_L(DELAY_L), .LE(LE), .DGATE(DGATE),
    .LOCKED(LOCKED), .SLOT_LEN(SLOT_LEN), .FMT_ERR(FMT_ERR), .LED1(LED1)
  );

  int checks = 0;
  int errors = 0;
  int n_fmt = 0, n_dgate = 0, n_le_low = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot-level description of the sequencer.
  // m_state: 0 search, 1 acquire, 2 locked. m_run counts consecutive equal
  // valid slots. LE is tracked as a window [m_le_start, m_le_end) of clocks.
  int m_state, m_cnt, m_lq, m_run, m_run_len, m_lock_len;
  int m_slot, m_dr, m_dl, m_c, m_le_start, m_le_end;
  bit m_dgate, m_fmt;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_lq = 0; m_run = 0; m_run_len = 0; m_lock_len = 0;
    m_slot = 0; m_dr = 11; m_dl = 43; m_dgate = 0; m_fmt = 0;
    m_le_start = -100; m_le_end = -100;
  endtask

  task automatic model_step();
    int  x, len, old;
    bit  edge_s, fall_s, stall_s, valid;
    m_c++;
    x       = int'(LRCK);
    edge_s  = (x != m_lq);
    fall_s  = edge_s && (x == 0);
    len     = (m_cnt + 1 > 63) ? 63 : m_cnt + 1;
    stall_s = (m_cnt == 63) && !edge_s;
    valid   = (len == 24) || (len == 32);
    old     = m_state;
    m_fmt   = 0;
    if (edge_s) m_slot = len;
    if (old == 0) begin
      if (edge_s) begin m_state = 1; m_run = 0; end
    end else if (stall_s) begin
      m_state = 0;
    end else if (edge_s && old == 1) begin
      if (valid && m_run > 0 && len == m_run_len) m_run++;
      else begin
        if (!valid || m_run > 0) m_fmt = 1;
        m_run = valid ? 1 : 0;
      end
      m_run_len = len;
      if (m_run == LOCK_HALVES) begin
        m_state = 2; m_lock_len = len;
        m_dr = len - DATA_BITS - 1; m_dl = m_dr + len;
      end
    end else if (edge_s && old == 2 && len != m_lock_len) begin
      m_fmt = 1; m_state = 1; m_run = 0;
    end
    if (m_state != 2) m_dgate = 0;
    else if (old == 2 && fall_s) m_dgate = 1;
    if (fall_s && m_dgate && m_c > m_le_end) begin
      m_le_start = m_c + 1;
      m_le_end   = m_c + 1 + LE_WIDTH;
    end
    m_cnt = edge_s ? 0 : ((m_cnt == 63) ? 63 : m_cnt + 1);
    m_lq  = x;
  endtask

  task automatic compare();
    bit exp_le;
    exp_le = !(m_c >= m_le_start && m_c < m_le_end);
    check("model", 64'({SLOT_LEN, DELAY_R, DELAY_L, LE, DGATE, LOCKED, FMT_ERR}),
          64'({6'(m_slot), 6'(m_dr), 7'(m_dl), exp_le, m_dgate, (m_state == 2), m_fmt}));
`ifdef LED_ACQ_BLINK_EN
    if (m_state == 2) check("led_locked", 64'(LED1), 64'(0));
    else if (m_state == 0) check("led_search", 64'(LED1), 64'(1));
`else
    check("led", 64'(LED1), 64'(m_state != 2));
`endif
    if (FMT_ERR) n_fmt++;
    if (DGATE) n_dgate++;
    if (!LE) n_le_low++;
  endtask

  task automatic tick();
    @(posedge BCK);
    #1;
    if (RST) model_reset();
    else model_step();
    compare();
  endtask

  task automatic run_slots(input int len, input int n);
    repeat (n) begin
      LRCK = ~LRCK;
      repeat (len) tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    LRCK = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  typedef struct {
    int         len;
    int         n;
    logic       exp_locked;
    logic [5:0] exp_slot;
    logic [5:0] exp_dr;
    logic [6:0] exp_dl;
    logic       exp_dgate;
  } vec_t;

  vec_t       tbl[6];
  logic [3:0] les;
  int         lens[7];

  initial begin
    tbl[0] = '{32, 4, 1'b0, 6'd32, 6'd11, 7'd43, 1'b0};
    tbl[1] = '{32, 5, 1'b1, 6'd32, 6'd11, 7'd43, 1'b0};
    tbl[2] = '{32, 8, 1'b1, 6'd32, 6'd11, 7'd43, 1'b1};
    tbl[3] = '{24, 8, 1'b1, 6'd24, 6'd3,  7'd27, 1'b1};
    tbl[4] = '{16, 8, 1'b0, 6'd16, 6'd11, 7'd43, 1'b0};
    tbl[5] = '{31, 8, 1'b0, 6'd31, 6'd11, 7'd43, 1'b0};
    lens   = '{32, 32, 24, 16, 31, 2, 70};
    m_c = 0;
    model_reset();

    // Reset applied mid-stream while locked and gated on.
    do_reset();
    run_slots(32, 8);
    LRCK = ~LRCK;
    repeat (5) tick();
    RST = 1'b1;
    #1;
    model_reset();
    check("rst_async", 64'({DELAY_R, DELAY_L, LE, DGATE, LOCKED, SLOT_LEN, FMT_ERR, LED1}),
          64'({6'd11, 7'd43, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1}));
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) LRCK = ~LRCK;
      tick();
      check("rst_hold", 64'({DELAY_R, DELAY_L, LE, DGATE, LOCKED, SLOT_LEN, FMT_ERR, LED1}),
            64'({6'd11, 7'd43, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1}));
    end
    RST = 1'b0;

    // Table: N slots of one length from reset, final state checked.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      n_fmt = 0; n_dgate = 0; n_le_low = 0;
      run_slots(tbl[i].len, tbl[i].n);
      check($sformatf("row%0d", i),
            64'({LOCKED, SLOT_LEN, DELAY_R, DELAY_L, DGATE}),
            64'({tbl[i].exp_locked, tbl[i].exp_slot, tbl[i].exp_dr, tbl[i].exp_dl, tbl[i].exp_dgate}));
      if (tbl[i].len == 16) begin
        check("fmt16_count", 64'(n_fmt), 64'(tbl[i].n - 1));
        check("gate16", 64'(n_dgate + n_le_low), 64'(0));
      end
    end

    // LE shape with 24-bit slots: high on the fall cycle, then low two cycles.
    do_reset();
    run_slots(24, 9);
    LRCK = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      les[3-k] = LE;
    end
    check("le_shape24", 64'(les), 64'(4'b1001));
    repeat (20) tick();

    // One 31-cycle slot while locked, then relock.
    do_reset();
    run_slots(32, 8);
    run_slots(31, 1);
    LRCK = ~LRCK;
    tick();
    check("mis_edge", 64'({FMT_ERR, LOCKED, DGATE}), 64'(3'b100));
    repeat (31) tick();
    run_slots(32, 3);
    check("relock_pre", 64'(LOCKED), 64'(0));
    LRCK = ~LRCK;
    tick();
    check("relock", 64'({LOCKED, DELAY_R, DELAY_L}), 64'({1'b1, 6'd11, 7'd43}));
    repeat (31) tick();

    // Lock lost by a 2-cycle slot while an LE pulse is running.
    run_slots(32, 1);
    LRCK = 1'b0;
    tick();
    tick();
    LRCK = 1'b1;
    tick();
    check("le_hold", 64'({LE, LOCKED, FMT_ERR, DGATE}), 64'(4'b0010));
    tick();
    check("le_done", 64'(LE), 64'(1));
    repeat (30) tick();

    // LRCK stalls right after a frame start while locked.
    do_reset();
    run_slots(32, 9);
    n_fmt = 0;
    LRCK = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (k < 4) les[3-k] = LE;
    end
    check("le_shape_stall", 64'(les), 64'(4'b1001));
    check("stall_unlock", 64'({LOCKED, DGATE, LED1}), 64'(3'b001));
    check("stall_nofmt", 64'(n_fmt), 64'(0));
    run_slots(32, 4);
    check("search_first_edge", 64'({n_fmt, 1'b0, LOCKED}), 64'(0));
    LRCK = ~LRCK;
    tick();
    check("stall_relock", 64'(LOCKED), 64'(1));
    repeat (31) tick();

    // Random bursts of slot lengths against the model.
    do_reset();
    for (int b = 0; b < 40; b++) begin
      run_slots(lens[$urandom_range(0, 6)], $urandom_range(1, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
